// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST fail-log block: FSM encodings,
// counter/element widths and a saturating-increment helper.
package mbist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOG  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int CNT_W  = 8;
    localparam int ELEM_W = 3;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

endpackage

// File: rtl/mbist_fail_fifo.sv
// Synchronous show-ahead FIFO holding fail-log entries. The head entry
// and its valid flag are registered, so the consumer sees a new entry one
// cycle after it is pushed and the head stays put until it is popped.
module mbist_fail_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         head_valid,
    output logic [W-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic [AW:0]  wr_ptr_n_s;
    logic [AW:0]  rd_ptr_n_s;
    logic         empty_s;
    logic         full_s;
    logic         push_ok_s;
    logic         pop_ok_s;
    logic [W-1:0] head_data_r;
    logic         head_valid_r;
    logic [W-1:0] head_data_n_s;

    // Occupancy flags, qualified push/pop and next pointers / next head entry.
    always_comb begin
        empty_s       = (wr_ptr_r == rd_ptr_r);
        full_s        = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_ok_s      = pop && !empty_s && !clear;
        // A push into a full FIFO is accepted when a pop frees a slot this cycle.
        push_ok_s     = push && !clear && (!full_s || pop_ok_s);
        wr_ptr_n_s    = wr_ptr_r;
        rd_ptr_n_s    = rd_ptr_r;
        head_data_n_s = head_data_r;
        if (clear) begin
            wr_ptr_n_s    = PTR_ZERO;
            rd_ptr_n_s    = PTR_ZERO;
            head_data_n_s = {W{1'b0}};
        end else begin
            wr_ptr_n_s = push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_n_s = pop_ok_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            if (wr_ptr_n_s == rd_ptr_n_s) begin
                head_data_n_s = head_data_r;
            end else if (push_ok_s && (wr_ptr_r[AW-1:0] == rd_ptr_n_s[AW-1:0])) begin
                // The slot becoming the head is being written right now.
                head_data_n_s = din;
            end else begin
                head_data_n_s = mem_r[rd_ptr_n_s[AW-1:0]];
            end
        end
    end

    // Entry storage; no reset needed because only the registered head is observed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Pointers and registered head entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            head_valid_r <= 1'b0;
            head_data_r  <= {W{1'b0}};
        end else begin
            wr_ptr_r     <= wr_ptr_n_s;
            rd_ptr_r     <= rd_ptr_n_s;
            head_valid_r <= (wr_ptr_n_s != rd_ptr_n_s);
            head_data_r  <= head_data_n_s;
        end
    end

    assign full       = full_s;
    assign head_valid = head_valid_r;
    assign head_data  = head_data_r;

endmodule

// File: rtl/mbist_fail_log.sv
// MBIST fail logger: tracks the test session with a small FSM, counts
// comparator mismatches, filters back-to-back duplicate failures and
// queues distinct failures in a show-ahead FIFO for a downstream reader.
module mbist_fail_log
    import mbist_pkg::*;
#(
    parameter int ADDR  = 6,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              fail_valid,
    input  logic [ADDR-1:0]   fail_addr,
    input  logic              fail_exp,
    input  logic [ELEM_W-1:0] fail_elem,
    input  logic              bist_done,
    input  logic              log_ready,
    output logic              log_valid,
    output logic [ADDR-1:0]   log_addr,
    output logic              log_exp,
    output logic [ELEM_W-1:0] log_elem,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              overflow,
    output logic              diag_done
);

    localparam int ENTRY_W = ADDR + 1 + ELEM_W;

    state_e             state_r;
    state_e             state_n_s;
    logic               mode_q_r;
    logic [CNT_W-1:0]   fail_cnt_r;
    logic               overflow_r;
    logic               diag_done_r;
    logic [ADDR-1:0]    last_addr_r;
    logic [ELEM_W-1:0]  last_elem_r;
    logic               last_valid_r;

    logic               mode_rise_s;
    logic               start_s;
    logic               fail_s;
    logic               dup_s;
    logic               push_s;
    logic               pop_s;
    logic               wrote_s;
    logic               drop_s;
    logic               fifo_full_s;
    logic               head_valid_s;
    logic [ENTRY_W-1:0] head_data_s;
    logic [ENTRY_W-1:0] din_s;

    // Session control, duplicate filter and push/pop/drop decisions.
    always_comb begin
        mode_rise_s = mode && !mode_q_r;
        start_s     = mode_rise_s && ((state_r == IDLE) || (state_r == DONE));
        fail_s      = (state_r == LOG) && fail_valid;
        dup_s       = last_valid_r && (last_addr_r == fail_addr) &&
                      (last_elem_r == fail_elem);
        pop_s       = head_valid_s && log_ready;
        push_s      = fail_s && !dup_s;
        wrote_s     = push_s && (!fifo_full_s || pop_s);
        drop_s      = push_s && fifo_full_s && !pop_s;
        din_s       = {fail_addr, fail_exp, fail_elem};
        state_n_s   = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_n_s = LOG;
                end else begin
                    state_n_s = IDLE;
                end
            end
            LOG: begin
                if (!mode) begin
                    state_n_s = IDLE;
                end else if (bist_done) begin
                    state_n_s = DONE;
                end else begin
                    state_n_s = LOG;
                end
            end
            DONE: begin
                if (start_s) begin
                    state_n_s = LOG;
                end else begin
                    state_n_s = DONE;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // FSM state, counters, sticky overflow and duplicate-filter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            // Held high so a mode level present across reset is not seen as a rise.
            mode_q_r     <= 1'b1;
            fail_cnt_r   <= {CNT_W{1'b0}};
            overflow_r   <= 1'b0;
            diag_done_r  <= 1'b0;
            last_addr_r  <= {ADDR{1'b0}};
            last_elem_r  <= {ELEM_W{1'b0}};
            last_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            mode_q_r    <= mode;
            diag_done_r <= (state_n_s == DONE);
            if (start_s) begin
                fail_cnt_r   <= {CNT_W{1'b0}};
                overflow_r   <= 1'b0;
                last_valid_r <= 1'b0;
            end else begin
                if (fail_s) begin
                    fail_cnt_r <= sat_inc(fail_cnt_r);
                end
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
                if (wrote_s) begin
                    last_addr_r  <= fail_addr;
                    last_elem_r  <= fail_elem;
                    last_valid_r <= 1'b1;
                end
            end
        end
    end

    mbist_fail_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_s),
        .push       (push_s),
        .pop        (pop_s),
        .din        (din_s),
        .full       (fifo_full_s),
        .head_valid (head_valid_s),
        .head_data  (head_data_s)
    );

    assign log_valid = head_valid_s;
    assign log_addr  = head_data_s[ENTRY_W-1 -: ADDR];
    assign log_exp   = head_data_s[ELEM_W];
    assign log_elem  = head_data_s[ELEM_W-1:0];
    assign fail_cnt  = fail_cnt_r;
    assign overflow  = overflow_r;
    assign diag_done = diag_done_r;

endmodule

// File: tb/tb_mbist_fail_log.sv
// Directed self-checking bench for mbist_fail_log (ADDR=6, DEPTH=4).
module tb_mbist_fail_log;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       fail_valid;
    logic [5:0] fail_addr;
    logic       fail_exp;
    logic [2:0] fail_elem;
    logic       bist_done;
    logic       log_ready;
    logic       log_valid;
    logic [5:0] log_addr;
    logic       log_exp;
    logic [2:0] log_elem;
    logic [7:0] fail_cnt;
    logic       overflow;
    logic       diag_done;

    int checks   = 0;
    int failures = 0;

    mbist_fail_log #(.ADDR(6), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .fail_valid (fail_valid),
        .fail_addr  (fail_addr),
        .fail_exp   (fail_exp),
        .fail_elem  (fail_elem),
        .bist_done  (bist_done),
        .log_ready  (log_ready),
        .log_valid  (log_valid),
        .log_addr   (log_addr),
        .log_exp    (log_exp),
        .log_elem   (log_elem),
        .fail_cnt   (fail_cnt),
        .overflow   (overflow),
        .diag_done  (diag_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fail(input logic [5:0] a, input logic [2:0] e, input logic x);
        fail_valid = 1'b1;
        fail_addr  = a;
        fail_elem  = e;
        fail_exp   = x;
        tick();
        fail_valid = 1'b0;
    endtask

    task automatic restart();
        mode = 1'b0;
        tick();
        mode = 1'b1;
        tick();
    endtask

    task automatic head_chk(input string tag, input logic [5:0] a, input logic x, input logic [2:0] e);
        chk({tag, "_valid"}, {31'd0, log_valid}, 32'd1);
        chk({tag, "_addr"},  {26'd0, log_addr},  {26'd0, a});
        chk({tag, "_exp"},   {31'd0, log_exp},   {31'd0, x});
        chk({tag, "_elem"},  {29'd0, log_elem},  {29'd0, e});
    endtask

    initial begin
        rst        = 1'b1;
        mode       = 1'b0;
        fail_valid = 1'b0;
        fail_addr  = 6'd0;
        fail_exp   = 1'b0;
        fail_elem  = 3'd0;
        bist_done  = 1'b0;
        log_ready  = 1'b0;
        #12;
        chk("rst_valid", {31'd0, log_valid}, 32'd0);
        chk("rst_addr",  {26'd0, log_addr},  32'd0);
        chk("rst_exp",   {31'd0, log_exp},   32'd0);
        chk("rst_elem",  {29'd0, log_elem},  32'd0);
        chk("rst_cnt",   {24'd0, fail_cnt},  32'd0);
        chk("rst_ovf",   {31'd0, overflow},  32'd0);
        chk("rst_diag",  {31'd0, diag_done}, 32'd0);
        rst = 1'b0;
        tick();
        tick();

        // Basic logging and in-order drain.
        mode = 1'b1;
        tick();
        chk("t1_empty", {31'd0, log_valid}, 32'd0);
        fail(6'h05, 3'd1, 1'b1);
        head_chk("t1_first", 6'h05, 1'b1, 3'd1);
        fail(6'h12, 3'd2, 1'b0);
        fail(6'h3F, 3'd3, 1'b1);
        chk("t1_cnt", {24'd0, fail_cnt}, 32'd3);
        chk("t1_ovf", {31'd0, overflow}, 32'd0);
        log_ready = 1'b1;
        head_chk("t1_pop0", 6'h05, 1'b1, 3'd1);
        tick();
        head_chk("t1_pop1", 6'h12, 1'b0, 3'd2);
        tick();
        head_chk("t1_pop2", 6'h3F, 1'b1, 3'd3);
        tick();
        chk("t1_drained", {31'd0, log_valid}, 32'd0);
        log_ready = 1'b0;

        // Overflow with six distinct failures and no reader.
        restart();
        chk("t2_cnt_clr", {24'd0, fail_cnt}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            fail(6'(i + 1), 3'd0, 1'b0);
        end
        chk("t2_cnt", {24'd0, fail_cnt}, 32'd6);
        chk("t2_ovf", {31'd0, overflow}, 32'd1);
        log_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", {26'd0, log_addr}, 32'(i + 1));
            tick();
        end
        chk("t2_drained", {31'd0, log_valid}, 32'd0);
        log_ready = 1'b0;

        // Full FIFO: push coinciding with pop is accepted.
        restart();
        chk("t3_ovf_clr", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            fail(6'(8 + i), 3'd1, 1'b1);
        end
        chk("t3_full_ovf", {31'd0, overflow}, 32'd0);
        chk("t3_full_cnt", {24'd0, fail_cnt}, 32'd4);
        log_ready = 1'b1;
        fail(6'h30, 3'd5, 1'b0);
        log_ready = 1'b0;
        chk("t3_ovf", {31'd0, overflow}, 32'd0);
        chk("t3_cnt", {24'd0, fail_cnt}, 32'd5);
        head_chk("t3_head", 6'h09, 1'b1, 3'd1);
        log_ready = 1'b1;
        tick();
        chk("t3_h1", {26'd0, log_addr}, 32'h0A);
        tick();
        chk("t3_h2", {26'd0, log_addr}, 32'h0B);
        tick();
        head_chk("t3_h3", 6'h30, 1'b0, 3'd5);
        tick();
        chk("t3_drained", {31'd0, log_valid}, 32'd0);
        log_ready = 1'b0;

        // Duplicate filter.
        restart();
        fail(6'h0A, 3'd2, 1'b1);
        fail(6'h0A, 3'd2, 1'b1);
        chk("t4_cnt", {24'd0, fail_cnt}, 32'd2);
        head_chk("t4_head", 6'h0A, 1'b1, 3'd2);
        log_ready = 1'b1;
        tick();
        chk("t4_one_entry", {31'd0, log_valid}, 32'd0);
        log_ready = 1'b0;
        fail(6'h0A, 3'd3, 1'b1);
        head_chk("t4_new_elem", 6'h0A, 1'b1, 3'd3);
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;

        // Saturation, bist_done and restart clearing.
        restart();
        for (int i = 0; i < 300; i++) begin
            fail(6'(i), 3'd4, 1'b0);
        end
        chk("t5_sat", {24'd0, fail_cnt}, 32'd255);
        chk("t5_ovf", {31'd0, overflow}, 32'd1);
        chk("t5_diag_pre", {31'd0, diag_done}, 32'd0);
        bist_done = 1'b1;
        tick();
        bist_done = 1'b0;
        chk("t5_diag", {31'd0, diag_done}, 32'd1);
        mode = 1'b0;
        tick();
        chk("t5_diag_hold", {31'd0, diag_done}, 32'd1);
        mode = 1'b1;
        tick();
        chk("t5_cnt_clr", {24'd0, fail_cnt}, 32'd0);
        chk("t5_ovf_clr", {31'd0, overflow}, 32'd0);
        chk("t5_fifo_clr", {31'd0, log_valid}, 32'd0);
        chk("t5_diag_clr", {31'd0, diag_done}, 32'd0);

        // Asynchronous reset mid-test.
        fail(6'h11, 3'd0, 1'b0);
        fail(6'h22, 3'd1, 1'b0);
        chk("t6_pre_valid", {31'd0, log_valid}, 32'd1);
        chk("t6_pre_cnt", {24'd0, fail_cnt}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, log_valid}, 32'd0);
        chk("t6_rst_cnt", {24'd0, fail_cnt}, 32'd0);
        chk("t6_rst_addr", {26'd0, log_addr}, 32'd0);
        #2;
        rst = 1'b0;
        tick();
        fail(6'h15, 3'd4, 1'b1);
        chk("t6_no_rise_cnt", {24'd0, fail_cnt}, 32'd0);
        chk("t6_no_rise_valid", {31'd0, log_valid}, 32'd0);
        restart();
        fail(6'h15, 3'd4, 1'b1);
        chk("t6_rerun_cnt", {24'd0, fail_cnt}, 32'd1);
        head_chk("t6_rerun", 6'h15, 1'b1, 3'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mbist_fail_log.md
MBIST_FAIL_LOG -- requirements
Module: mbist_fail_log

Interface
REQ-001 SHALL have parameter ADDR, default 6, meaning memory address width as {row addr, col addr}.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of fail-log entries; it is a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset; asynchronous, active-high.
REQ-005 SHALL have port mode, input, 1 bit, meaning BIST test mode is active.
REQ-006 SHALL have port fail_valid, input, 1 bit, meaning a one-cycle pulse from the BIST comparator on a read mismatch.
REQ-007 SHALL have port fail_addr, input, ADDR bits, meaning the failing address.
REQ-008 SHALL have port fail_exp, input, 1 bit, meaning the expected read data.
REQ-009 SHALL have port fail_elem, input, 3 bits, meaning the March element index at the time of the failure.
REQ-010 SHALL have port bist_done, input, 1 bit, meaning the BIST sequence has completed.
REQ-011 SHALL have port log_ready, input, 1 bit, meaning the consumer accepts the head entry.
REQ-012 SHALL have port log_valid, output, 1 bit, meaning the head entry is presented.
REQ-013 SHALL have port log_addr, output, ADDR bits, meaning the head entry's address.
REQ-014 SHALL have port log_exp, output, 1 bit, meaning the head entry's expected data.
REQ-015 SHALL have port log_elem, output, 3 bits, meaning the head entry's March element.
REQ-016 SHALL have port fail_cnt, output, 8 bits, meaning the total mismatch count, saturating.
REQ-017 SHALL have port overflow, output, 1 bit, meaning at least one failure was dropped.
REQ-018 SHALL have port diag_done, output, 1 bit, meaning the log is final.

Function
REQ-019 SHALL use FSM states IDLE, LOG and DONE: IDLE->LOG on the rising edge of mode; LOG->DONE on bist_done; DONE->LOG on the next rising edge of mode; any state->IDLE when mode is 0 while not in DONE.
REQ-020 SHALL, on the IDLE->LOG or DONE->LOG transition, clear the FIFO, fail_cnt and overflow in that same cycle; failures in that cycle are ignored.
REQ-021 SHALL, in LOG with fail_valid=1, increment fail_cnt, saturating at 255.
REQ-022 SHALL, in LOG with fail_valid=1 and the FIFO not full, write {fail_addr, fail_exp, fail_elem} at the tail, visible on log_* at the earliest 1 cycle later (show-ahead head).
REQ-023 SHALL suppress the write when fail_addr and fail_elem equal the most recently written entry; fail_cnt still increments; the duplicate register clears at start.
REQ-024 SHALL, on fail_valid with the FIFO full and no pop in that cycle, drop the entry and set overflow, which is sticky until the next start.
REQ-025 SHALL pop when log_valid and log_ready are both 1; a simultaneous pop and push on a full FIFO accepts the push with no overflow.
REQ-026 SHALL drive log_valid as FIFO not empty; log_* hold stable while log_valid=1 and log_ready=0.
REQ-027 SHALL allow pops in every state; pushes occur only in LOG.
REQ-028 SHALL register diag_done as 1 in DONE and 0 elsewhere, asserting 1 cycle after bist_done is sampled.
REQ-029 SHALL wrap FIFO pointers modulo DEPTH and use an extra MSB to tell full from empty.

Reset
REQ-030 SHALL, while rst=1, asynchronously force: state IDLE, FIFO empty, log_valid=0, log_addr=0, log_exp=0, log_elem=0, fail_cnt=0, overflow=0, diag_done=0.
REQ-031 SHALL, if rst asserts mid-test, discard all entries; after release, logging requires a new rising edge of mode.

Structure
REQ-032 SHALL take the FSM state encodings, the fail_cnt width (8) and the element-index width (3) from shared package mbist_pkg.
REQ-033 SHALL instantiate one sub-module, mbist_fail_fifo (parameterised synchronous show-ahead FIFO); the FSM, duplicate filter and counters stay in mbist_fail_log.

Verification
REQ-034 SHALL cover: ADDR=6, DEPTH=4, mode rise, fails at 0x05, 0x12, 0x3F -> log_valid 1 cycle after the first; entries pop in order with log_ready=1; fail_cnt=3; overflow=0.
REQ-035 SHALL cover: 6 distinct fails with log_ready=0 -> 4 entries held; overflow=1; fail_cnt=6.
REQ-036 SHALL cover: FIFO full, fail_valid coinciding with a pop -> entry accepted; overflow stays 0.
REQ-037 SHALL cover: fail at 0x0A elem 2 twice in a row -> 1 entry; fail_cnt=2.
REQ-038 SHALL cover: 300 fails -> fail_cnt=255; bist_done -> diag_done=1 the next cycle; a new mode rise clears fail_cnt, overflow and the FIFO.
REQ-039 SHALL cover: rst pulse with 2 entries logged -> log_valid=0 and fail_cnt=0 immediately, with no clock edge.
